shift_engine: RTL and testbench

Parametrised successor to the team's fixed 8-bit shift register. It is a WIDTH-bit shift/rotate register with selectable direction, parallel load, serial in/out, and a burst counter that shifts a programmed number of bits and then flags completion. It sits between the input conditioners (shift/load pulses) and the serial peripheral pins or LEDs, and is the building block for the upcoming SPI-style serial link.

---
 rtl/shift_engine_if.sv | 29 ++
 rtl/shift_engine.sv | 107 ++++++++++
 tb/tb_shift_engine.sv | 220 ++++++++++++++++++++++
 3 files changed

// File: rtl/shift_engine_if.sv
// rtl/shift_engine_if.sv - control/data bundle between a shift_engine and its driver
interface shift_engine_if #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 8
);
    logic             shift_en;
    logic             parallel_load;
    logic [WIDTH-1:0] parallel_data_in;
    logic             serial_data_in;
    logic [1:0]       mode;
    logic             start;
    logic [CNT_W-1:0] burst_len;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] parallel_data_out;
    logic             serial_data_out;

    modport master (
        output shift_en, parallel_load, parallel_data_in, serial_data_in,
               mode, start, burst_len,
        input  busy, done, parallel_data_out, serial_data_out
    );

    modport slave (
        input  shift_en, parallel_load, parallel_data_in, serial_data_in,
               mode, start, burst_len,
        output busy, done, parallel_data_out, serial_data_out
    );
endinterface

// File: rtl/shift_engine.sv
// rtl/shift_engine.sv - WIDTH-bit shift/rotate register with burst counter
// Optional SHIFTENGINE_EDGE_DETECT_EN: shift_en treated as a raw level, synchronised and edge-detected.
module shift_engine #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    shift_engine_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        SHIFTING = 2'd1,
        DONE     = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_next;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_next;
    logic [WIDTH-1:0] r_data;
    logic             w_shift;

`ifdef SHIFTENGINE_EDGE_DETECT_EN
    logic r_sync1;
    logic r_sync2;
    logic r_prev;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_prev  <= 1'b0;
        end else begin
            r_sync1 <= bus.shift_en;
            r_sync2 <= r_sync1;
            r_prev  <= r_sync2;
        end
    end

    assign w_shift = r_sync2 & ~r_prev;
`else
    assign w_shift = bus.shift_en;
`endif

    // Load beats shift; a coinciding shift pulse is simply dropped.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_data <= '0;
        end else if (bus.parallel_load) begin
            r_data <= bus.parallel_data_in;
        end else if (w_shift) begin
            case (bus.mode)
                2'b00:   r_data <= {r_data[WIDTH-2:0], bus.serial_data_in};
                2'b01:   r_data <= {bus.serial_data_in, r_data[WIDTH-1:1]};
                2'b10:   r_data <= {r_data[WIDTH-2:0], r_data[WIDTH-1]};
                default: r_data <= {r_data[0], r_data[WIDTH-1:1]};
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        case (r_state)
            IDLE: begin
                if (bus.start && (bus.burst_len != '0)) begin
                    w_state_next = SHIFTING;
                    w_cnt_next   = bus.burst_len;
                end
            end
            SHIFTING: begin
                if (bus.parallel_load) begin
                    w_state_next = IDLE;
                    w_cnt_next   = '0;
                end else if (w_shift) begin
                    w_cnt_next = r_cnt - CNT_W'(1);
                    if (r_cnt == CNT_W'(1)) begin
                        w_state_next = DONE;
                    end
                end
            end
            DONE: begin
                w_state_next = IDLE;
            end
            default: begin
                w_state_next = IDLE;
                w_cnt_next   = '0;
            end
        endcase
    end

    assign bus.busy              = (r_state == SHIFTING);
    assign bus.done              = (r_state == DONE);
    assign bus.parallel_data_out = r_data;
    assign bus.serial_data_out   = bus.mode[0] ? r_data[0] : r_data[WIDTH-1];
endmodule

// File: tb/tb_shift_engine.sv
// tb/tb_shift_engine.sv - directed self-checking bench for shift_engine
module tb_shift_engine;
    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_fail;

    shift_engine_if #(.WIDTH(8), .CNT_W(8)) bus ();

    shift_engine #(.WIDTH(8), .CNT_W(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One effective shift; returns just after the edge that updates the register.
    task automatic pulse();
        bus.shift_en = 1'b1;
        tick();
        bus.shift_en = 1'b0;
`ifdef SHIFTENGINE_EDGE_DETECT_EN
        tick();
        tick();
`endif
    endtask

    task automatic load(input logic [7:0] d);
        bus.parallel_load    = 1'b1;
        bus.parallel_data_in = d;
        tick();
        bus.parallel_load    = 1'b0;
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst_n                = 1'b0;
        bus.shift_en         = 1'b0;
        bus.parallel_load    = 1'b0;
        bus.parallel_data_in = '0;
        bus.serial_data_in   = 1'b0;
        bus.mode             = 2'b00;
        bus.start            = 1'b0;
        bus.burst_len        = '0;
        tick();
        check("rst_data", bus.parallel_data_out, 0);
        check("rst_busy", bus.busy, 0);
        check("rst_done", bus.done, 0);
        check("rst_sout", bus.serial_data_out, 0);
        rst_n = 1'b1;
        tick();

        // Shift left with serial_data_in = 1
        load(8'hA5);
        check("load_a5", bus.parallel_data_out, 8'hA5);
        bus.mode = 2'b00;
        bus.serial_data_in = 1'b1;
        check("sl_sout0", bus.serial_data_out, 1);
        pulse();
        check("sl_data0", bus.parallel_data_out, 8'h4B);
        check("sl_sout1", bus.serial_data_out, 0);
        pulse();
        check("sl_data1", bus.parallel_data_out, 8'h97);
        check("sl_sout2", bus.serial_data_out, 1);
        pulse();
        check("sl_final", bus.parallel_data_out, 8'h2F);

        // Rotates
        load(8'hA5);
        bus.mode = 2'b11;
        check("rr_sout", bus.serial_data_out, 1);
        pulse();
        check("rr_data", bus.parallel_data_out, 8'hD2);
        load(8'hA5);
        bus.mode = 2'b10;
        bus.serial_data_in = 1'b0;
        pulse();
        check("rl_data", bus.parallel_data_out, 8'h4B);

        // Shift right pulls serial_data_in into the MSB
        load(8'h02);
        bus.mode = 2'b01;
        bus.serial_data_in = 1'b1;
        pulse();
        check("sr_data", bus.parallel_data_out, 8'h81);

        // Burst of 4 with an ignored start mid-burst
        load(8'h01);
        bus.mode = 2'b00;
        bus.serial_data_in = 1'b0;
        bus.start = 1'b1;
        bus.burst_len = 8'd4;
        tick();
        bus.start = 1'b0;
        check("burst_busy_start", bus.busy, 1);
        for (int i = 0; i < 4; i++) begin
            repeat (4) tick();
            if (i == 1) begin
                bus.start = 1'b1;
                bus.burst_len = 8'd9;
                tick();
                bus.start = 1'b0;
            end
            pulse();
            if (i < 3) begin
                check("burst_busy_mid", bus.busy, 1);
                check("burst_done_mid", bus.done, 0);
            end else begin
                check("burst_busy_end", bus.busy, 0);
                check("burst_done_end", bus.done, 1);
            end
        end
        check("burst_data", bus.parallel_data_out, 8'h10);
        tick();
        check("burst_done_clr", bus.done, 0);
        check("burst_busy_clr", bus.busy, 0);

        // Zero-length start is ignored
        bus.start = 1'b1;
        bus.burst_len = 8'd0;
        tick();
        bus.start = 1'b0;
        check("zero_len_busy", bus.busy, 0);

        // Burst aborted by a load after two shifts
        bus.start = 1'b1;
        bus.burst_len = 8'd4;
        tick();
        bus.start = 1'b0;
        pulse();
        pulse();
        check("abort_busy_pre", bus.busy, 1);
        load(8'h3C);
        check("abort_data", bus.parallel_data_out, 8'h3C);
        check("abort_busy", bus.busy, 0);
        for (int i = 0; i < 6; i++) begin
            check("abort_no_done", bus.done, 0);
            tick();
        end

`ifndef SHIFTENGINE_EDGE_DETECT_EN
        // Load and shift in the same cycle during a burst
        bus.start = 1'b1;
        bus.burst_len = 8'd3;
        tick();
        bus.start = 1'b0;
        bus.parallel_load = 1'b1;
        bus.parallel_data_in = 8'h81;
        bus.shift_en = 1'b1;
        tick();
        bus.parallel_load = 1'b0;
        bus.shift_en = 1'b0;
        check("coinc_data", bus.parallel_data_out, 8'h81);
        check("coinc_busy", bus.busy, 0);
        tick();
        check("coinc_done", bus.done, 0);
`else
        // A long high level yields exactly one shift, on the third edge
        load(8'h81);
        bus.mode = 2'b00;
        bus.serial_data_in = 1'b0;
        bus.shift_en = 1'b1;
        tick();
        check("ed_edge1", bus.parallel_data_out, 8'h81);
        tick();
        check("ed_edge2", bus.parallel_data_out, 8'h81);
        tick();
        check("ed_edge3", bus.parallel_data_out, 8'h02);
        for (int i = 0; i < 7; i++) begin
            tick();
            check("ed_hold", bus.parallel_data_out, 8'h02);
        end
        bus.shift_en = 1'b0;
        repeat (3) tick();
        check("ed_release", bus.parallel_data_out, 8'h02);
`endif

        // Asynchronous reset mid-burst
        load(8'hF0);
        bus.start = 1'b1;
        bus.burst_len = 8'd4;
        tick();
        bus.start = 1'b0;
        pulse();
        check("rst_pre_data", bus.parallel_data_out, 8'hE0);
        check("rst_pre_busy", bus.busy, 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_data", bus.parallel_data_out, 0);
        check("arst_busy", bus.busy, 0);
        check("arst_done", bus.done, 0);
        check("arst_sout", bus.serial_data_out, 0);
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("post_rst_done", bus.done, 0);
        end

        $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
        $finish;
    end
endmodule
